// File: rtl/dcache_responder_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM encoding, address-field width helpers and the store byte-merge.
package dcache_responder_pkg;

    localparam int WORD_W             = 32;
    localparam int ADDR_W             = 30;
    localparam int DEF_NUM_LINES      = 8;
    localparam int DEF_WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    function automatic int offset_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int words_per_line, input int num_lines);
        return ADDR_W - offset_w(words_per_line) - index_w(num_lines);
    endfunction

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [3:0]        byte_en
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data storage for the cache. Valid and dirty clear on reset;
// tag and data arrays are left uninitialised.
module dcache_line_store
    import dcache_responder_pkg::*;
#(
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int OFFSET_W       = offset_w(WORDS_PER_LINE),
    parameter int INDEX_W        = index_w(NUM_LINES),
    parameter int TAG_W          = tag_w(WORDS_PER_LINE, NUM_LINES),
    parameter int LINE_W         = WORD_W * WORDS_PER_LINE
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [INDEX_W-1:0]  index,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [LINE_W-1:0]   rd_line,
    input  logic                word_we,
    input  logic [OFFSET_W-1:0] word_offset,
    input  logic [3:0]          word_be,
    input  logic [WORD_W-1:0]   word_data,
    input  logic                line_we,
    input  logic [TAG_W-1:0]    line_tag,
    input  logic [LINE_W-1:0]   line_data,
    input  logic                clean_en
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (line_we) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
            if (word_we) begin
                dirty_q[index] <= 1'b1;
            end
            if (clean_en) begin
                dirty_q[index] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[index]  <= line_tag;
            data_q[index] <= line_data;
        end else if (word_we) begin
            data_q[index][WORD_W*word_offset +: WORD_W] <=
                byte_merge(data_q[index][WORD_W*word_offset +: WORD_W], word_data, word_be);
        end
    end

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_line  = data_q[index];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache between the memory
// stage and the memory bus. Misses evict (if dirty) and refill whole lines.
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    localparam int OFFSET_W      = offset_w(WORDS_PER_LINE),
    localparam int INDEX_W       = index_w(NUM_LINES),
    localparam int TAG_W         = tag_w(WORDS_PER_LINE, NUM_LINES),
    localparam int LINE_W        = WORD_W * WORDS_PER_LINE,
    localparam int LINE_ADDR_W   = ADDR_W - OFFSET_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic [3:0]             write_en_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [WORD_W-1:0]      wdata_i,
    output logic [WORD_W-1:0]      rdata_o,
    output logic                   busywait_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [LINE_ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0]      mem_wdata_o,
    input  logic [LINE_W-1:0]      mem_rdata_i,
    input  logic                   mem_ack_i,
    output logic [1:0]             dbg_state_o
);

    // Memory handshake: mem_req_o rises with the transaction and holds,
    // together with mem_we_o/mem_addr_o/mem_wdata_o, until the cycle in which
    // mem_ack_i pulses; that cycle completes it. Acks seen in IDLE are ignored.

    state_t                state_q;
    logic [OFFSET_W-1:0]   offset;
    logic [INDEX_W-1:0]    index;
    logic [TAG_W-1:0]      tag;
    logic                  victim_valid;
    logic                  victim_dirty;
    logic [TAG_W-1:0]      victim_tag;
    logic [LINE_W-1:0]     victim_line;
    logic                  hit;
    logic                  miss;
    logic                  word_we;
    logic                  line_we;
    logic                  clean_en;

    assign offset = addr_i[OFFSET_W-1:0];
    assign index  = addr_i[OFFSET_W +: INDEX_W];
    assign tag    = addr_i[OFFSET_W+INDEX_W +: TAG_W];

    dcache_line_store #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .OFFSET_W       (OFFSET_W),
        .INDEX_W        (INDEX_W),
        .TAG_W          (TAG_W),
        .LINE_W         (LINE_W)
    ) u_store (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .index       (index),
        .rd_valid    (victim_valid),
        .rd_dirty    (victim_dirty),
        .rd_tag      (victim_tag),
        .rd_line     (victim_line),
        .word_we     (word_we),
        .word_offset (offset),
        .word_be     (write_en_i),
        .word_data   (wdata_i),
        .line_we     (line_we),
        .line_tag    (tag),
        .line_data   (mem_rdata_i),
        .clean_en    (clean_en)
    );

    assign hit  = req_i && victim_valid && (victim_tag == tag);
    assign miss = req_i && !hit;

    assign word_we  = (state_q == IDLE) && hit && (write_en_i != 4'b0000);
    assign line_we  = (state_q == REFILL) && mem_ack_i;
    assign clean_en = (state_q == WRITEBACK) && mem_ack_i;

    assign rdata_o = victim_line[WORD_W*offset +: WORD_W];

    // Gating with rst_i keeps busywait low while reset is held, even though
    // every line reads invalid then.
    assign busywait_o  = rst_i && ((state_q != IDLE) || miss);
    assign dbg_state_o = state_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        mem_req_o <= 1'b1;
                        if (victim_valid && victim_dirty) begin
                            state_q     <= WRITEBACK;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= {victim_tag, index};
                            mem_wdata_o <= victim_line;
                        end else begin
                            state_q    <= REFILL;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {tag, index};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q    <= REFILL;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {tag, index};
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state_q   <= IDLE;
                        mem_req_o <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
